logic_exec_stage: RTL and testbench

- Two-stage pipelined execute wrapper placed directly upstream of the logic-function unit.
- Stage 1 accepts decoded logic ops from decode over a valid/ready handshake and registers the operands and opcode that drive the logic unit's a/b/logicidx/active inputs.
- Stage 2 captures the unit's combinational result, derives N/Z flags and presents a tagged result to writeback over a valid/ready handshake.
- Guarantees the logic unit never sees an unsupported opcode.

---
 rtl/logic_exec_stage_pkg.sv | 23 ++
 rtl/logic_exec_stage_pipe_reg.sv | 66 ++++++
 rtl/logic_exec_stage.sv | 143 ++++++++++++++
 tb/tb_logic_exec_stage.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_exec_stage_pkg.sv
// ---------------------------------------------------------------------------
// logic_exec_stage_pkg
//   Shared definitions for the logic execute stage:
//   - opcode encodings understood by the downstream logic-function unit
//   - op_legal(): true for opcodes the logic unit supports
//   - default datapath width
// ---------------------------------------------------------------------------
package logic_exec_stage_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;

  // Encodings 101..111 are reserved; everything up to NOR is supported.
  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_NOR);
  endfunction

endpackage

// File: rtl/logic_exec_stage_pipe_reg.sv
// ---------------------------------------------------------------------------
// pipe_reg_stage
//   Generic one-entry valid/ready payload register.
//
//   Handshake: a transfer happens on any rising edge where valid and ready
//   are both high on that interface. in_ready never depends on in_valid.
//   A full register can be refilled in the same cycle it drains.
//
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     flush         synchronous kill: entry dropped, incoming data discarded
//     in_valid      upstream offers in_data
//     in_ready      register can take data this cycle (empty or draining)
//     in_data       payload in
//     out_valid     register holds an entry
//     out_ready     downstream takes the entry this cycle
//     out_data      payload out (held while stalled and after draining)
// ---------------------------------------------------------------------------
module pipe_reg_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  assign in_ready  = !valid_q | out_ready;
  assign load      = in_valid & in_ready & !flush;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      // Drained with no refill: payload is kept, only valid drops.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/logic_exec_stage.sv
// ---------------------------------------------------------------------------
// logic_exec_stage
//   Two-stage execute wrapper in front of a combinational logic-function unit.
//   Stage 1 registers operands/opcode that feed the unit (lu_*); stage 2
//   captures the unit result, derives N/Z and offers a tagged result to
//   writeback. Illegal opcodes never reach the unit: they are sent as AND
//   with the unit disabled and complete with a zero result and out_err=1.
//
//   Handshakes (both sides): transfer on a rising edge with valid & ready.
//   in_ready = !s1_valid | s2_free, where s2_free = !s2_valid | out_ready.
//   Accepted op at edge k is presented on out_* after edge k+1.
//
//   Ports:
//     clk, rst            clock, async active-high reset
//     flush               synchronous kill of both stages (done_cnt kept)
//     in_valid/in_ready   decode handshake
//     in_op,in_a,in_b     opcode and operands
//     in_rd,in_setflags   destination tag, N/Z update request
//     lu_a,lu_b,lu_idx    registered unit inputs
//     lu_active           unit enable (stage 1 holds a legal op)
//     lu_o                unit result, combinational from lu_*
//     out_valid/out_ready writeback handshake
//     out_result,out_rd   result and tag
//     out_n,out_z         sign and zero flags of out_result
//     out_flags_we        writeback should update N/Z
//     out_err             op had an illegal opcode
//     done_cnt            saturating count of completed writeback transfers
// ---------------------------------------------------------------------------
module logic_exec_stage
  import logic_exec_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RDW   = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [RDW-1:0]   in_rd,
  input  logic             in_setflags,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [2:0]       lu_idx,
  output logic             lu_active,
  input  logic [WIDTH-1:0] lu_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RDW-1:0]   out_rd,
  output logic             out_n,
  output logic             out_z,
  output logic             out_flags_we,
  output logic             out_err,
  output logic [CNTW-1:0]  done_cnt
);

  // Stage 1 payload: {a, b, idx, rd, setflags, err}
  localparam int S1W = 2 * WIDTH + 3 + RDW + 2;
  // Stage 2 payload: {result, rd, n, z, err, setflags}
  localparam int S2W = WIDTH + RDW + 4;

  // ---------------- stage 1 ----------------
  logic           in_legal;
  logic [2:0]     s1_idx_in;
  logic [S1W-1:0] s1_in_data, s1_data;
  logic           s1_valid;
  logic           s2_free;
  logic [RDW-1:0] s1_rd;
  logic           s1_setflags;
  logic           s1_err;

  assign in_legal   = op_legal(in_op);
  // Illegal ops are parked as AND so the unit only ever sees a legal index.
  assign s1_idx_in  = in_legal ? in_op : OP_AND;
  assign s1_in_data = {in_a, in_b, s1_idx_in, in_rd, in_setflags, !in_legal};

  pipe_reg_stage #(.W(S1W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_valid),
    .out_ready (s2_free),
    .out_data  (s1_data)
  );

  assign {lu_a, lu_b, lu_idx, s1_rd, s1_setflags, s1_err} = s1_data;
  // Enable only while a legal op occupies stage 1; both terms are flops.
  assign lu_active = s1_valid & !s1_err;

  // ---------------- stage 2 ----------------
  logic [WIDTH-1:0] s2_result_in;
  logic [S2W-1:0]   s2_in_data, s2_data;
  logic             s2_setflags;

  assign s2_result_in = s1_err ? '0 : lu_o;
  // N/Z are computed at capture so the outputs are plain registers.
  assign s2_in_data   = {s2_result_in, s1_rd, s2_result_in[WIDTH-1],
                         (s2_result_in == '0), s1_err, s1_setflags};

  pipe_reg_stage #(.W(S2W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (s1_valid),
    .in_ready  (s2_free),
    .in_data   (s2_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign {out_result, out_rd, out_n, out_z, out_err, s2_setflags} = s2_data;
  assign out_flags_we = s2_setflags & !out_err & out_valid;

  // ---------------- completed-op counter ----------------
  logic [CNTW-1:0] done_cnt_q, done_cnt_d;

  always_comb begin
    done_cnt_d = done_cnt_q;
    if (out_valid && out_ready && (done_cnt_q != {CNTW{1'b1}})) begin
      done_cnt_d = done_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt_q <= '0;
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end

  assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_logic_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_logic_exec_stage
//   Directed table vectors, hand-written multi-cycle sequences (throughput,
//   backpressure, flush, async reset) and a randomized run, all checked
//   against a scoreboard of expected results built from the opcode rules.
// ---------------------------------------------------------------------------
module tb_logic_exec_stage;

  localparam int WIDTH = 32;
  localparam int RDW   = 4;
  localparam int CNTW  = 16;
  localparam int EW    = WIDTH + RDW + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = '0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [RDW-1:0]   in_rd = '0;
  logic             in_setflags = 1'b0;
  logic [WIDTH-1:0] lu_a, lu_b, lu_o;
  logic [2:0]       lu_idx;
  logic             lu_active;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic [RDW-1:0]   out_rd;
  logic             out_n, out_z, out_flags_we, out_err;
  logic [CNTW-1:0]  done_cnt;

  logic_exec_stage #(.WIDTH(WIDTH), .RDW(RDW), .CNTW(CNTW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_rd        (in_rd),
    .in_setflags  (in_setflags),
    .lu_a         (lu_a),
    .lu_b         (lu_b),
    .lu_idx       (lu_idx),
    .lu_active    (lu_active),
    .lu_o         (lu_o),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_n        (out_n),
    .out_z        (out_z),
    .out_flags_we (out_flags_we),
    .out_err      (out_err),
    .done_cnt     (done_cnt)
  );

  // Stand-in for the external logic-function unit.
  always_comb begin
    lu_o = 32'hDEAD_BEEF;
    unique case (lu_idx)
      3'd0: lu_o = lu_a & lu_b;
      3'd1: lu_o = lu_a | lu_b;
      3'd2: lu_o = lu_a ^ lu_b;
      3'd3: lu_o = ~(lu_a & lu_b);
      3'd4: lu_o = ~(lu_a | lu_b);
      default: lu_o = 32'hDEAD_BEEF;
    endcase
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference result: {err, flags_we, z, n, rd, result}
  function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b, input logic [RDW-1:0] rd,
                                          input logic sf);
    logic [WIDTH-1:0] r;
    logic             err;
    err = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      default: begin r = '0; err = 1'b1; end
    endcase
    return {err, sf & ~err, (r == '0), r[WIDTH-1], rd, r};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0]   exp_q[$];
  logic [CNTW-1:0] exp_done = '0;

  // Sampled mid-cycle; the handshakes seen here complete at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_done = '0;
    end else begin
      // At most two ops in flight; with both stages full only out_ready frees a slot.
      chk("in_ready_rule", in_ready, (exp_q.size() < 2) || out_ready);
      chk("done_cnt_track", done_cnt, exp_done);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
        else begin
          chk("out_payload", {out_err, out_flags_we, out_z, out_n, out_rd, out_result}, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (exp_done != {CNTW{1'b1}}) exp_done = exp_done + 1'b1;
          end
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready)
        exp_q.push_back(model(in_op, in_a, in_b, in_rd, in_setflags));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [RDW-1:0] rd, input logic sf);
    in_valid    = v;
    in_op       = op;
    in_a        = a;
    in_b        = b;
    in_rd       = rd;
    in_setflags = sf;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;
    logic [RDW-1:0]   rd;
    logic             sf;
    logic [WIDTH-1:0] res;
    logic             n, z, we, err;
  } vec_t;

  vec_t vecs[7];

  logic [2:0]       bb_ops[4];
  logic [WIDTH-1:0] bp_a[5], bp_b[5];
  logic [EW-1:0]    first_exp;
  logic [CNTW-1:0]  cnt_base;

  initial begin
    vecs[0] = '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 4'd3,  1'b1, 32'hF000F000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{3'b001, 32'h0000FFFF, 32'h00FF00FF, 4'd1,  1'b1, 32'h00FFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{3'b010, 32'h0000FFFF, 32'h00FF00FF, 4'd2,  1'b0, 32'h00FFFF00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{3'b011, 32'h0000FFFF, 32'h00FF00FF, 4'd7,  1'b1, 32'hFFFFFF00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{3'b100, 32'h0000FFFF, 32'h00FF00FF, 4'd15, 1'b1, 32'hFF000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{3'b110, 32'hFFFFFFFF, 32'h12345678, 4'd9,  1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{3'b010, 32'hA5A5A5A5, 32'hA5A5A5A5, 4'd4,  1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0};
    bb_ops = '{3'b001, 3'b010, 3'b011, 3'b100};

    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lu_active", lu_active, 0);
    chk("rst_lu_a", lu_a, 0);
    chk("rst_lu_b", lu_b, 0);
    chk("rst_lu_idx", lu_idx, 0);
    chk("rst_out_bus", {out_result, out_rd, out_n, out_z, out_flags_we, out_err}, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // Single ops, one at a time, with fixed latency checks.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].sf);
      next_cycle();                      // accept edge
      drive(1'b0, 3'd0, '0, '0, '0, 1'b0);
      @(negedge clk);                    // op sits in stage 1
      chk("vec_lu_active", lu_active, !vecs[i].err);
      chk("vec_lu_idx", lu_idx, vecs[i].err ? 3'd0 : vecs[i].op);
      chk("vec_lu_a", lu_a, vecs[i].a);
      chk("vec_early_valid", out_valid, 0);
      @(negedge clk);                    // op in stage 2
      chk("vec_out_valid", out_valid, 1);
      chk("vec_result", out_result, vecs[i].res);
      chk("vec_rd", out_rd, vecs[i].rd);
      chk("vec_nz", {out_n, out_z}, {vecs[i].n, vecs[i].z});
      chk("vec_flags_we", out_flags_we, vecs[i].we);
      chk("vec_err", out_err, vecs[i].err);
      @(negedge clk);
      chk("vec_done_cnt", done_cnt, i + 1);
      chk("vec_drained", out_valid, 0);
    end

    // Back-to-back OR/XOR/NAND/NOR at full rate.
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      if (c < 4) drive(1'b1, bb_ops[c], 32'h0000FFFF, 32'h00FF00FF, c[3:0], 1'b1);
      else       drive(1'b0, 3'd0, '0, '0, '0, 1'b0);
      @(negedge clk);
      chk("b2b_in_ready", in_ready, 1);
      chk("b2b_out_valid", out_valid, (c >= 2) && (c <= 5));
    end

    // Backpressure: 5 ops, writeback stalled for 4 cycles.
    cnt_base = done_cnt;
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = $urandom();
      bp_b[i] = $urandom();
    end
    first_exp = model(3'd0, bp_a[0], bp_b[0], 4'd0, 1'b1);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      drive(1'b1, (c < 2) ? c[2:0] : 3'd2, bp_a[(c < 2) ? c : 2], bp_b[(c < 2) ? c : 2],
            (c < 2) ? c[3:0] : 4'd2, 1'b1);
      @(negedge clk);
      chk("bp_in_ready", in_ready, c < 2);
      if (c >= 2) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_result", out_result, first_exp[WIDTH-1:0]);
      end
    end
    for (int i = 2; i < 5; i++) begin
      next_cycle();
      out_ready = 1'b1;
      drive(1'b1, i[2:0], bp_a[i], bp_b[i], i[3:0], 1'b1);
    end
    next_cycle();
    drive(1'b0, 3'd0, '0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_done_cnt", done_cnt, cnt_base + 5);

    // Flush with both stages full and a new op offered.
    cnt_base = done_cnt;
    out_ready = 1'b0;
    next_cycle(); drive(1'b1, 3'd1, 32'h1, 32'h2, 4'd5, 1'b1);
    next_cycle(); drive(1'b1, 3'd2, 32'h3, 32'h4, 4'd6, 1'b1);
    next_cycle(); drive(1'b1, 3'd0, 32'h5, 32'h6, 4'd7, 1'b1); flush = 1'b1;
    @(negedge clk);
    chk("fl_full_in_ready", in_ready, 0);
    chk("fl_full_valid", out_valid, 1);
    next_cycle(); flush = 1'b0; drive(1'b0, 3'd0, '0, '0, '0, 1'b0);
    @(negedge clk);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_lu_active", lu_active, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("fl_quiet", out_valid, 0);
    end
    chk("fl_done_cnt", done_cnt, cnt_base);
    // Flush on an empty pipe overrides an accept that in_ready allows.
    next_cycle(); drive(1'b1, 3'd1, 32'h7, 32'h8, 4'd1, 1'b1); flush = 1'b1;
    @(negedge clk);
    chk("fl_empty_in_ready", in_ready, 1);
    next_cycle(); flush = 1'b0; drive(1'b0, 3'd0, '0, '0, '0, 1'b0);
    @(negedge clk);
    chk("fl_discard_active", lu_active, 0);
    @(negedge clk);
    chk("fl_discard_valid", out_valid, 0);

    // Async reset in the middle of a stall.
    out_ready = 1'b0;
    next_cycle(); drive(1'b1, 3'd3, 32'hFFFF0000, 32'h0F0F0F0F, 4'd8, 1'b1);
    next_cycle(); drive(1'b1, 3'd4, 32'h00000001, 32'h00000002, 4'd9, 1'b1);
    next_cycle(); drive(1'b0, 3'd0, '0, '0, '0, 1'b0);
    @(negedge clk);
    chk("ar_pre_valid", out_valid, 1);
    chk("ar_pre_active", lu_active, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_lu_active", lu_active, 0);
    chk("ar_done_cnt", done_cnt, 0);
    chk("ar_in_ready", in_ready, 1);
    exp_q.delete();
    exp_done = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ar_after_valid", out_valid, 0);

    // Randomized traffic; the scoreboard does the checking.
    for (int c = 0; c < 400; c++) begin
      logic [WIDTH-1:0] ra;
      next_cycle();
      ra = $urandom();
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), ra,
            ($urandom_range(0, 3) == 0) ? ra : $urandom(), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 24) == 0;
    end
    next_cycle();
    drive(1'b0, 3'd0, '0, '0, '0, 1'b0);
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_idle_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
